// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - control FSM sequencing a multi-cycle MIPS datapath
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [5:0]       OpCode,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic             bus_err,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12,
        S_HALT   = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam int              WAIT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            r_state;
    state_t            w_next;
    logic [WAIT_W-1:0] r_wait;
    logic              r_illegal;
    logic              r_bus_err;
    logic [CNT_W-1:0]  r_count;
    logic              w_mem_state;
    logic              w_timeout;
    logic              w_bad_op;
    logic              w_retire;

    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    // Ready on the last allowed wait cycle still counts as a normal completion.
    assign w_timeout   = w_mem_state && !mem_ready && (r_wait == WAIT_LAST);
    assign w_bad_op    = (r_state == S_DECODE) &&
                         !(OpCode == OP_RTYPE || OpCode == OP_LW || OpCode == OP_SW ||
                           OpCode == OP_BEQ   || OpCode == OP_J  || OpCode == OP_ADDI);
    assign w_retire    = (w_next == S_FETCH) &&
                         (r_state == S_MEMWB || r_state == S_MEMWR || r_state == S_RWB ||
                          r_state == S_BRANCH || r_state == S_JUMP || r_state == S_ADDIWB);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_wait    <= '0;
            r_illegal <= 1'b0;
            r_bus_err <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_wait <= '0;
            else if (w_mem_state && !mem_ready)
                r_wait <= r_wait + WAIT_W'(1);
            if (w_bad_op)
                r_illegal <= 1'b1;
            if (w_timeout)
                r_bus_err <= 1'b1;
            if (w_retire)
                r_count <= r_count + CNT_W'(1);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (run) w_next = S_FETCH;
            S_FETCH:  if (w_timeout) w_next = S_HALT;
                      else if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (OpCode)
                    OP_RTYPE:      w_next = S_EXEC;
                    OP_LW, OP_SW:  w_next = S_MEMADR;
                    OP_BEQ:        w_next = S_BRANCH;
                    OP_J:          w_next = S_JUMP;
                    OP_ADDI:       w_next = S_ADDIEX;
                    default:       w_next = S_HALT;
                endcase
            end
            S_MEMADR: w_next = (OpCode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (w_timeout) w_next = S_HALT;
                      else if (mem_ready) w_next = S_MEMWB;
            S_MEMWR:  if (w_timeout) w_next = S_HALT;
                      else if (mem_ready) w_next = S_FETCH;
            S_MEMWB:  w_next = S_FETCH;
            S_EXEC:   w_next = S_RWB;
            S_RWB:    w_next = S_FETCH;
            S_BRANCH: w_next = S_FETCH;
            S_JUMP:   w_next = S_FETCH;
            S_ADDIEX: w_next = S_ADDIWB;
            S_ADDIWB: w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        case (r_state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: ALUSrcB = 2'b11;
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_ADDIWB: RegWrite = 1'b1;
            default: ;
        endcase
    end

    assign state       = r_state;
    assign illegal_op  = r_illegal;
    assign bus_err     = r_bus_err;
    assign instr_count = r_count;

endmodule
